// File: rtl/os_array_ctrl.sv
// Sequencer for an output-stationary PE array: clear, feed K, flush skew, drain rows.
// Optional active-cycle counter enabled by `define OS_CTRL_PERF_CNT_EN.
module os_array_ctrl #(
    parameter int ARRAY_N = 4,
    parameter int K_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start_i,
    input  logic [K_WIDTH-1:0]         k_len_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       acc_clr_o,
    output logic                       acc_en_o,
    output logic                       feed_rd_en_o,
    output logic [K_WIDTH-1:0]         feed_idx_o,
    output logic                       drain_valid_o,
    output logic [$clog2(ARRAY_N)-1:0] drain_row_o,
    input  logic                       drain_ready_i,
    output logic [31:0]                perf_cycles_o
);

    localparam int RW        = $clog2(ARRAY_N);
    localparam int FLUSH_LEN = 2 * ARRAY_N - 2;
    localparam int FW        = $clog2(2 * ARRAY_N);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH,
        DRAIN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [K_WIDTH-1:0] k_q, k_d;
    logic [K_WIDTH-1:0] idx_q, idx_d;
    logic [FW-1:0]      flush_q, flush_d;
    logic [RW-1:0]      row_q, row_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               clr_q, clr_d;
    logic               en_q, en_d;
    logic               rd_q, rd_d;
    logic               dv_q, dv_d;
    state_t             after_feed;

    // Skip the flush phase entirely when the array has no skew to drain
    assign after_feed = (FLUSH_LEN > 0) ? FLUSH : DRAIN;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = CLEAR;
                    k_d     = k_len_i;
                end
            end
            CLEAR: begin
                state_d = (k_q == '0) ? DRAIN : FEED;
            end
            FEED: begin
                if (idx_q == k_q - K_WIDTH'(1)) begin
                    state_d = after_feed;
                end
            end
            FLUSH: begin
                if (flush_q == FW'(FLUSH_LEN - 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_ready_i && row_q == RW'(ARRAY_N - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output registers are loaded from the next state so every output is a flop
    always_comb begin
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        clr_d   = (state_d == CLEAR);
        en_d    = (state_d == FEED) || (state_d == FLUSH);
        rd_d    = (state_d == FEED);
        dv_d    = (state_d == DRAIN);
        idx_d   = '0;
        flush_d = '0;
        row_d   = '0;
        if (state_d == FEED && state_q == FEED) begin
            idx_d = idx_q + K_WIDTH'(1);
        end
        if (state_d == FLUSH && state_q == FLUSH) begin
            flush_d = flush_q + FW'(1);
        end
        if (state_d == DRAIN && state_q == DRAIN) begin
            row_d = drain_ready_i ? row_q + RW'(1) : row_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            k_q     <= '0;
            idx_q   <= '0;
            flush_q <= '0;
            row_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clr_q   <= 1'b0;
            en_q    <= 1'b0;
            rd_q    <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            idx_q   <= idx_d;
            flush_q <= flush_d;
            row_q   <= row_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            clr_q   <= clr_d;
            en_q    <= en_d;
            rd_q    <= rd_d;
            dv_q    <= dv_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign acc_clr_o     = clr_q;
    assign acc_en_o      = en_q;
    assign feed_rd_en_o  = rd_q;
    assign feed_idx_o    = idx_q;
    assign drain_valid_o = dv_q;
    assign drain_row_o   = row_q;

`ifdef OS_CTRL_PERF_CNT_EN
    logic [31:0] run_q, run_d;
    logic [31:0] perf_q, perf_d;

    // The DRAIN cycle that hands off to DONE is still an active cycle
    always_comb begin
        run_d  = (state_q == IDLE || state_q == DONE) ? '0 : run_q + 32'd1;
        perf_d = (state_d == DONE) ? run_q + 32'd1 : perf_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_q  <= '0;
            perf_q <= '0;
        end else begin
            run_q  <= run_d;
            perf_q <= perf_d;
        end
    end

    assign perf_cycles_o = perf_q;
`else
    assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_os_array_ctrl.sv
// Directed bench for os_array_ctrl with ARRAY_N=4, K_WIDTH=8.
module tb_os_array_ctrl;

`ifdef OS_CTRL_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        start_i;
    logic [7:0]  k_len_i;
    logic        busy_o;
    logic        done_o;
    logic        acc_clr_o;
    logic        acc_en_o;
    logic        feed_rd_en_o;
    logic [7:0]  feed_idx_o;
    logic        drain_valid_o;
    logic [1:0]  drain_row_o;
    logic        drain_ready_i;
    logic [31:0] perf_cycles_o;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    os_array_ctrl #(.ARRAY_N(4), .K_WIDTH(8)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .start_i       (start_i),
        .k_len_i       (k_len_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .acc_clr_o     (acc_clr_o),
        .acc_en_o      (acc_en_o),
        .feed_rd_en_o  (feed_rd_en_o),
        .feed_idx_o    (feed_idx_o),
        .drain_valid_o (drain_valid_o),
        .drain_row_o   (drain_row_o),
        .drain_ready_i (drain_ready_i),
        .perf_cycles_o (perf_cycles_o)
    );

    function automatic logic [15:0] obs();
        return {busy_o, done_o, acc_clr_o, acc_en_o, feed_rd_en_o,
                feed_idx_o, drain_valid_o, drain_row_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [7:0] k);
        start_i = 1'b1;
        k_len_i = k;
        tick();
        start_i = 1'b0;
        k_len_i = 8'hAA;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        start_i = 1'b0;
        k_len_i = '0;
        drain_ready_i = 1'b1;
        #3;
        checks++;
        if (obs() !== 16'h0 || perf_cycles_o !== 32'd0) begin
            errs++;
            $display("FAIL reset got=%h/%0d exp=0/0", obs(), perf_cycles_o);
        end
        tick();
        rstn = 1'b1;
        tick();
        checks++;
        if (obs() !== 16'h0) begin
            errs++;
            $display("FAIL reset_idle got=%h exp=0", obs());
        end
    endtask

    // K=3: CLEAR 1, FEED 2-4, FLUSH 5-10, DRAIN 11-14, DONE 15
    task automatic test_basic();
        logic [15:0] e;
        drain_ready_i = 1'b1;
        start_job(8'd3);
        for (int c = 1; c <= 16; c++) begin
            e = {(c >= 1 && c <= 15), (c == 15), (c == 1),
                 (c >= 2 && c <= 10), (c >= 2 && c <= 4),
                 (c >= 2 && c <= 4) ? 8'(c - 2) : 8'd0,
                 (c >= 11 && c <= 14),
                 (c >= 11 && c <= 14) ? 2'(c - 11) : 2'd0};
            checks++;
            if (obs() !== e) begin
                errs++;
                $display("FAIL basic c=%0d got=%h exp=%h", c, obs(), e);
            end
            if (c < 16) tick();
        end
        checks++;
        if (perf_cycles_o !== (PERF_ON ? 32'd14 : 32'd0)) begin
            errs++;
            $display("FAIL basic_perf got=%0d exp=%0d",
                     perf_cycles_o, PERF_ON ? 14 : 0);
        end
    endtask

    // K=0: CLEAR 1, DRAIN 2-5, DONE 6
    task automatic test_k0();
        int en_seen = 0;
        int done_c = -1;
        start_job(8'd0);
        for (int c = 1; c <= 10; c++) begin
            if (acc_en_o || feed_rd_en_o) en_seen++;
            if (done_o && done_c < 0) done_c = c;
            if (c == 2) begin
                checks++;
                if (drain_valid_o !== 1'b1 || drain_row_o !== 2'd0) begin
                    errs++;
                    $display("FAIL k0_drain got=%b/%0d exp=1/0",
                             drain_valid_o, drain_row_o);
                end
            end
            tick();
        end
        checks++;
        if (en_seen !== 0) begin
            errs++;
            $display("FAIL k0_en got=%0d exp=0", en_seen);
        end
        checks++;
        if (done_c !== 6) begin
            errs++;
            $display("FAIL k0_done got=%0d exp=6", done_c);
        end
        checks++;
        if (perf_cycles_o !== (PERF_ON ? 32'd5 : 32'd0)) begin
            errs++;
            $display("FAIL k0_perf got=%0d exp=%0d",
                     perf_cycles_o, PERF_ON ? 5 : 0);
        end
    endtask

    // K=1: DRAIN from 9, row 2 at 11 stalled 3 cycles, DONE at 16
    task automatic test_stall();
        int done_c = -1;
        int hold_bad = 0;
        start_job(8'd1);
        for (int c = 1; c <= 20; c++) begin
            drain_ready_i = !(c >= 11 && c <= 13);
            if (c >= 11 && c <= 14) begin
                if (drain_valid_o !== 1'b1 || drain_row_o !== 2'd2)
                    hold_bad++;
            end
            if (done_o && done_c < 0) done_c = c;
            tick();
        end
        drain_ready_i = 1'b1;
        checks++;
        if (hold_bad !== 0) begin
            errs++;
            $display("FAIL stall_hold got=%0d bad cycles exp=0", hold_bad);
        end
        checks++;
        if (done_c !== 16) begin
            errs++;
            $display("FAIL stall_done got=%0d exp=16", done_c);
        end
        checks++;
        if (perf_cycles_o !== (PERF_ON ? 32'd15 : 32'd0)) begin
            errs++;
            $display("FAIL stall_perf got=%0d exp=%0d",
                     perf_cycles_o, PERF_ON ? 15 : 0);
        end
    endtask

    // K=2: FEED 2-3, DONE 14; start pulses at 2 and 14 are dropped
    task automatic test_ignore_start();
        int dones = 0;
        start_job(8'd2);
        for (int c = 1; c <= 24; c++) begin
            start_i = (c == 2 || c == 14);
            k_len_i = 8'd5;
            if (done_o) dones++;
            if (c == 3) begin
                checks++;
                if (feed_idx_o !== 8'd1) begin
                    errs++;
                    $display("FAIL ign_idx got=%0d exp=1", feed_idx_o);
                end
            end
            if (c == 14) begin
                checks++;
                if (done_o !== 1'b1) begin
                    errs++;
                    $display("FAIL ign_done got=%b exp=1", done_o);
                end
            end
            if (c == 16) begin
                checks++;
                if (busy_o !== 1'b0) begin
                    errs++;
                    $display("FAIL ign_busy got=%b exp=0", busy_o);
                end
            end
            tick();
        end
        start_i = 1'b0;
        checks++;
        if (dones !== 1) begin
            errs++;
            $display("FAIL ign_count got=%0d exp=1", dones);
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        int done_c = -1;
        start_job(8'd3);
        repeat (5) tick();
        checks++;
        if (acc_en_o !== 1'b1 || feed_rd_en_o !== 1'b0) begin
            errs++;
            $display("FAIL mid_flush got=%b%b exp=10", acc_en_o, feed_rd_en_o);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (obs() !== 16'h0 || perf_cycles_o !== 32'd0) begin
            errs++;
            $display("FAIL mid_async got=%h/%0d exp=0/0", obs(), perf_cycles_o);
        end
        tick();
        rstn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (done_o || busy_o) dones++;
            tick();
        end
        checks++;
        if (dones !== 0) begin
            errs++;
            $display("FAIL mid_quiet got=%0d exp=0", dones);
        end
        start_job(8'd2);
        for (int c = 1; c <= 18; c++) begin
            if (done_o && done_c < 0) done_c = c;
            tick();
        end
        checks++;
        if (done_c !== 14) begin
            errs++;
            $display("FAIL mid_rejob got=%0d exp=14", done_c);
        end
        checks++;
        if (perf_cycles_o !== (PERF_ON ? 32'd13 : 32'd0)) begin
            errs++;
            $display("FAIL mid_perf got=%0d exp=%0d",
                     perf_cycles_o, PERF_ON ? 13 : 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_k0();
        test_stall();
        test_ignore_start();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
